// File: rtl/pixel_cache.sv
// pixel_cache: single-line read cache in front of a 1-bit-per-pixel frame
// memory (640x480, 40 words of 16 pixels per row).
// Optional feature: define PIXEL_CACHE_STATS_EN to add saturating
// hit_count / miss_count outputs. The default build has no statistics ports.
module pixel_cache (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        request,
    input  logic        invalidate,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        pixel,
    output logic        ready,
    output logic [14:0] mem_addr,
    output logic        mem_rd
`ifdef PIXEL_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_RD,
        MISS_WAIT,
        RESP,
        GUARD1,
        GUARD2
    } state_t;

    state_t      state;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [15:0] line_data;
    logic [14:0] line_tag;
    logic        line_valid;
    // Set when the frame changes while a fill is outstanding: the returned
    // word still answers the pending request but must not become cached.
    logic        drop_fill;

    logic [14:0] word_addr;
    logic [3:0]  bit_idx;
    logic        in_frame;
    logic        hit;

    // Address decode of the latched coordinates: row * 40 words + word column.
    assign word_addr = {5'd0, req_y} * 15'd40 + {9'd0, req_x[9:4]};
    assign bit_idx   = req_x[3:0];
    assign in_frame  = (req_x < 10'd640) && (req_y < 10'd480);
    assign hit       = line_valid && (line_tag == word_addr);

    // Request sequencer with registered outputs and the line valid bit.
    // NOTE: all state here uses non-blocking assignments so every branch
    // sees the pre-edge values, and later assignments (invalidate) win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_x      <= '0;
            req_y      <= '0;
            pixel      <= 1'b0;
            ready      <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            line_valid <= 1'b0;
            drop_fill  <= 1'b0;
        end else begin
            ready  <= 1'b0;
            mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        req_x <= x;
                        req_y <= y;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!in_frame) begin
                        pixel <= 1'b0;
                        ready <= 1'b1;
                        state <= RESP;
                    end else if (hit) begin
                        pixel <= line_data[bit_idx];
                        ready <= 1'b1;
                        state <= RESP;
                    end else begin
                        mem_rd    <= 1'b1;
                        mem_addr  <= word_addr;
                        drop_fill <= 1'b0;
                        state     <= MISS_RD;
                    end
                end
                MISS_RD: begin
                    state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (mem_valid) begin
                        pixel      <= mem_rdata[bit_idx];
                        ready      <= 1'b1;
                        line_valid <= !drop_fill;
                        state      <= RESP;
                    end
                end
                RESP:    state <= GUARD1;
                GUARD1:  state <= GUARD2;
                GUARD2:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Invalidate overrides any fill landing in the same cycle.
            if (invalidate) begin
                line_valid <= 1'b0;
                if (state == MISS_RD || state == MISS_WAIT)
                    drop_fill <= 1'b1;
            end
        end
    end

    // Line payload and tag capture on a fill.
    // NOTE: data and tag carry no reset; line_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && state == MISS_WAIT && mem_valid) begin
            line_data <= mem_rdata;
            line_tag  <= mem_addr;
        end
    end

`ifdef PIXEL_CACHE_STATS_EN
    // Saturating lookup statistics; out-of-frame lookups count as hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (!in_frame || hit) begin
                if (hit_count != 16'hFFFF)
                    hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF)
                    miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
